if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS core. It sits directly upstream of the ID-stage main decoder and feeds it the instruction word whose [31:26] becomes OP.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes ID-stage BRANCH/EQNE/JMP controls plus the rs==rt compare to redirect the PC; honours hazard-unit stalls.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/if_id_reg.sv | 48 ++++
 rtl/if_stage.sv | 210 +++++++++++++++++++++
 tb/tb_if_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding, NOP word, primary
// opcodes used by the ID-stage decoder, and the PC increment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] SPECIAL = 6'h00;
  localparam logic [5:0] J       = 6'h02;
  localparam logic [5:0] BEQ     = 6'h04;
  localparam logic [5:0] BNE     = 6'h05;
  localparam logic [5:0] ADDI    = 6'h08;
  localparam logic [5:0] SLTI    = 6'h0a;
  localparam logic [5:0] ANDI    = 6'h0c;
  localparam logic [5:0] ORI     = 6'h0d;
  localparam logic [5:0] LW      = 6'h23;
  localparam logic [5:0] SW      = 6'h2b;

  // Sequential PC; wraps modulo 2^32 without any exception
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    pc_plus4 = pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. When load is high it captures either a bubble
// (NOP, valid=0) or the supplied instruction/PC+4 (valid=1); otherwise holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst,
  input  logic [31:0] pcplus4,
  output logic [31:0] instd,
  output logic [31:0] pcplus4d,
  output logic        validd
);

  logic [31:0] inst_r;
  logic [31:0] pcplus4_r;
  logic        valid_r;

  // Pipeline register: async clear, load a bubble or real instruction, else hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_r    <= NOP;
      pcplus4_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
    end else if (load) begin
      if (bubble) begin
        inst_r    <= NOP;
        pcplus4_r <= 32'h0000_0000;
        valid_r   <= 1'b0;
      end else begin
        inst_r    <= inst;
        pcplus4_r <= pcplus4;
        valid_r   <= 1'b1;
      end
    end else begin
      inst_r    <= inst_r;
      pcplus4_r <= pcplus4_r;
      valid_r   <= valid_r;
    end
  end

  assign instd    = inst_r;
  assign pcplus4d = pcplus4_r;
  assign validd   = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake
// and IF/ID register. Optional macro BRANCH_DELAY_SLOT_EN keeps the
// instruction after a branch/jump (MIPS delay slot) instead of flushing it.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        CLK,
  input  logic        CLRN,
  input  logic        STALLD,
  input  logic        BRANCHD,
  input  logic        EQNED,
  input  logic        JMPD,
  input  logic        EQUALD,
  input  logic [31:0] PCBRANCHD,
  input  logic [31:0] PCJUMPD,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTD,
  output logic [31:0] PCPLUS4D,
  output logic        VALIDD
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  tgt_r;      // redirect target latched while waiting in DISCARD
  logic [31:0]  buf_inst_r; // word captured while stalled
  logic [31:0]  buf_pc4_r;  // its PC+4
  logic [31:0]  buf_npc_r;  // PC to resume from when leaving HOLD
  logic         req_r;

  logic         taken_s;
  logic         redirect_s;
  logic [31:0]  sel_s;
  logic [31:0]  target_s;
  logic         rdy_s;
  logic [31:0]  pc4_s;
  logic         ifid_load_s;
  logic         ifid_bubble_s;
  logic [31:0]  ifid_inst_s;
  logic [31:0]  ifid_pc4_s;

  // A stalled branch is still sitting in ID, so redirects wait for the stall to clear
  assign taken_s    = BRANCHD & (EQNED ? ~EQUALD : EQUALD);
  assign redirect_s = ~STALLD & (JMPD | taken_s);
  assign sel_s      = JMPD ? PCJUMPD : PCBRANCHD;
  assign target_s   = sel_s & 32'hFFFF_FFFC;
  // RDY only counts while a request is actually outstanding (not right after reset)
  assign rdy_s      = IMEM_RDY & req_r;
  assign pc4_s      = pc_plus4(pc_r);

  // IF/ID load/bubble selection for the current state and handshake outcome
  always_comb begin
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    ifid_inst_s   = IMEM_RDATA;
    ifid_pc4_s    = pc4_s;
    case (state_r)
      FETCH: begin
        if (rdy_s && redirect_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
          ifid_load_s   = 1'b1;
`else
          ifid_load_s   = 1'b1;
          ifid_bubble_s = 1'b1;
`endif
        end else if (rdy_s && !STALLD) begin
          ifid_load_s = 1'b1;
        end else if (rdy_s) begin
          ifid_load_s = 1'b0;
        end else if (redirect_s || !STALLD) begin
          ifid_load_s   = 1'b1;
          ifid_bubble_s = 1'b1;
        end else begin
          ifid_load_s = 1'b0;
        end
      end
      HOLD: begin
        ifid_inst_s = buf_inst_r;
        ifid_pc4_s  = buf_pc4_r;
        if (redirect_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
          ifid_load_s   = 1'b1;
`else
          ifid_load_s   = 1'b1;
          ifid_bubble_s = 1'b1;
`endif
        end else if (!STALLD) begin
          ifid_load_s = 1'b1;
        end else begin
          ifid_load_s = 1'b0;
        end
      end
      DISCARD: begin
`ifdef BRANCH_DELAY_SLOT_EN
        if (rdy_s && !STALLD) begin
          ifid_load_s = 1'b1;
        end else if (!STALLD) begin
          ifid_load_s   = 1'b1;
          ifid_bubble_s = 1'b1;
        end else begin
          ifid_load_s = 1'b0;
        end
`else
        if (!STALLD) begin
          ifid_load_s   = 1'b1;
          ifid_bubble_s = 1'b1;
        end else begin
          ifid_load_s = 1'b0;
        end
`endif
      end
      default: begin
        ifid_load_s = 1'b0;
      end
    endcase
  end

  // Fetch FSM with PC, redirect target, stall buffer and registered request
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC & 32'hFFFF_FFFC;
      tgt_r      <= 32'h0000_0000;
      buf_inst_r <= NOP;
      buf_pc4_r  <= 32'h0000_0000;
      buf_npc_r  <= 32'h0000_0000;
      req_r      <= 1'b0;
    end else begin
      req_r <= 1'b1;
      case (state_r)
        FETCH: begin
          if (rdy_s && redirect_s) begin
            pc_r <= target_s;
          end else if (rdy_s && !STALLD) begin
            pc_r <= pc4_s;
          end else if (rdy_s) begin
            buf_inst_r <= IMEM_RDATA;
            buf_pc4_r  <= pc4_s;
            buf_npc_r  <= pc4_s;
            state_r    <= HOLD;
            req_r      <= 1'b0;
          end else if (redirect_s) begin
            tgt_r   <= target_s;
            state_r <= DISCARD;
          end else begin
            pc_r <= pc_r;
          end
        end
        HOLD: begin
          if (redirect_s) begin
            pc_r    <= target_s;
            state_r <= FETCH;
          end else if (!STALLD) begin
            pc_r    <= buf_npc_r;
            state_r <= FETCH;
          end else begin
            req_r <= 1'b0;
          end
        end
        DISCARD: begin
          if (rdy_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (STALLD) begin
              // Slot word arrived during a stall: park it, resume at the target
              buf_inst_r <= IMEM_RDATA;
              buf_pc4_r  <= pc4_s;
              buf_npc_r  <= tgt_r;
              state_r    <= HOLD;
              req_r      <= 1'b0;
            end else begin
              pc_r    <= redirect_s ? target_s : tgt_r;
              state_r <= FETCH;
            end
`else
            pc_r    <= redirect_s ? target_s : tgt_r;
            state_r <= FETCH;
`endif
          end else if (redirect_s) begin
            tgt_r <= target_s;
          end else begin
            tgt_r <= tgt_r;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

  assign IMEM_REQ  = req_r;
  assign IMEM_ADDR = pc_r;

  if_id_reg u_if_id_reg (
    .clk      (CLK),
    .clrn     (CLRN),
    .load     (ifid_load_s),
    .bubble   (ifid_bubble_s),
    .inst     (ifid_inst_s),
    .pcplus4  (ifid_pc4_s),
    .instd    (INSTD),
    .pcplus4d (PCPLUS4D),
    .validd   (VALIDD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage (default build, flush-on-redirect behaviour).
module tb_if_stage;

  logic        clk;
  logic        clrn;
  logic        stalld;
  logic        branchd;
  logic        eqned;
  logic        jmpd;
  logic        equald;
  logic [31:0] pcbranchd;
  logic [31:0] pcjumpd;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] instd;
  logic [31:0] pcplus4d;
  logic        validd;

  int n_checks;
  int n_fails;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .CLK        (clk),
    .CLRN       (clrn),
    .STALLD     (stalld),
    .BRANCHD    (branchd),
    .EQNED      (eqned),
    .JMPD       (jmpd),
    .EQUALD     (equald),
    .PCBRANCHD  (pcbranchd),
    .PCJUMPD    (pcjumpd),
    .IMEM_REQ   (imem_req),
    .IMEM_ADDR  (imem_addr),
    .IMEM_RDY   (imem_rdy),
    .IMEM_RDATA (imem_rdata),
    .INSTD      (instd),
    .PCPLUS4D   (pcplus4d),
    .VALIDD     (validd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    clrn       = 1'b0;
    stalld     = 1'b0;
    branchd    = 1'b0;
    eqned      = 1'b0;
    jmpd       = 1'b0;
    equald     = 1'b0;
    pcbranchd  = 32'h0;
    pcjumpd    = 32'h0;
    imem_rdy   = 1'b1;
    imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_3000);
    chk("rst_inst",  instd, 32'h0);
    chk("rst_pc4",   pcplus4d, 32'h0);
    chk("rst_valid", {31'd0, validd}, 32'd0);
    clrn = 1'b1;

    // First cycle after release: request raised at RESET_PC
    tick();
    chk("rel_req",   {31'd0, imem_req}, 32'd1);
    chk("rel_addr",  imem_addr, 32'h0000_3000);
    chk("rel_valid", {31'd0, validd}, 32'd0);

    // Zero-wait streaming
    imem_rdata = 32'h1111_0001;
    tick();
    chk("seq1_addr",  imem_addr, 32'h0000_3004);
    chk("seq1_inst",  instd, 32'h1111_0001);
    chk("seq1_pc4",   pcplus4d, 32'h0000_3004);
    chk("seq1_valid", {31'd0, validd}, 32'd1);
    imem_rdata = 32'h2222_0002;
    tick();
    chk("seq2_addr", imem_addr, 32'h0000_3008);
    chk("seq2_inst", instd, 32'h2222_0002);
    chk("seq2_pc4",  pcplus4d, 32'h0000_3008);

    // Stall for two cycles with RDY high: word buffered, IF/ID held
    imem_rdata = 32'h3333_0003;
    stalld     = 1'b1;
    tick();
    chk("st1_req",  {31'd0, imem_req}, 32'd0);
    chk("st1_inst", instd, 32'h2222_0002);
    chk("st1_addr", imem_addr, 32'h0000_3008);
    imem_rdata = 32'hDEAD_0000;
    tick();
    chk("st2_req",   {31'd0, imem_req}, 32'd0);
    chk("st2_inst",  instd, 32'h2222_0002);
    chk("st2_valid", {31'd0, validd}, 32'd1);
    stalld = 1'b0;
    tick();
    chk("st3_inst", instd, 32'h3333_0003);
    chk("st3_pc4",  pcplus4d, 32'h0000_300C);
    chk("st3_addr", imem_addr, 32'h0000_300C);
    chk("st3_req",  {31'd0, imem_req}, 32'd1);
    imem_rdata = 32'h4444_0004;
    tick();
    chk("st4_inst", instd, 32'h4444_0004);
    chk("st4_addr", imem_addr, 32'h0000_3010);

    // bne taken: redirect to 0x3040 with one bubble
    branchd    = 1'b1;
    eqned      = 1'b1;
    equald     = 1'b0;
    pcbranchd  = 32'h0000_3040;
    imem_rdata = 32'h5555_0005;
    tick();
    chk("bne_addr",  imem_addr, 32'h0000_3040);
    chk("bne_valid", {31'd0, validd}, 32'd0);
    chk("bne_inst",  instd, 32'h0);
    branchd    = 1'b0;
    eqned      = 1'b0;
    imem_rdata = 32'h6666_0006;
    tick();
    chk("bne2_inst",  instd, 32'h6666_0006);
    chk("bne2_valid", {31'd0, validd}, 32'd1);
    chk("bne2_addr",  imem_addr, 32'h0000_3044);

    // beq with unequal operands: not taken, sequential, no bubble
    branchd    = 1'b1;
    eqned      = 1'b0;
    equald     = 1'b0;
    imem_rdata = 32'h7777_0007;
    tick();
    chk("beq_addr",  imem_addr, 32'h0000_3048);
    chk("beq_inst",  instd, 32'h7777_0007);
    chk("beq_valid", {31'd0, validd}, 32'd1);
    branchd = 1'b0;

    // Jump to 0x3101 with memory not ready for three cycles
    jmpd     = 1'b1;
    pcjumpd  = 32'h0000_3101;
    imem_rdy = 1'b0;
    tick();
    chk("jmp1_addr",  imem_addr, 32'h0000_3048);
    chk("jmp1_req",   {31'd0, imem_req}, 32'd1);
    chk("jmp1_valid", {31'd0, validd}, 32'd0);
    jmpd = 1'b0;
    tick();
    chk("jmp2_addr", imem_addr, 32'h0000_3048);
    tick();
    chk("jmp3_addr", imem_addr, 32'h0000_3048);
    imem_rdy   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    tick();
    chk("jmp4_addr",  imem_addr, 32'h0000_3100);
    chk("jmp4_valid", {31'd0, validd}, 32'd0);
    chk("jmp4_inst",  instd, 32'h0);
    imem_rdata = 32'h8888_0008;
    tick();
    chk("jmp5_inst", instd, 32'h8888_0008);
    chk("jmp5_pc4",  pcplus4d, 32'h0000_3104);
    chk("jmp5_addr", imem_addr, 32'h0000_3104);

    // Taken beq during a stall: held until the stall clears
    branchd    = 1'b1;
    eqned      = 1'b0;
    equald     = 1'b1;
    pcbranchd  = 32'h0000_3200;
    stalld     = 1'b1;
    imem_rdata = 32'h9999_0009;
    tick();
    chk("bst1_addr", imem_addr, 32'h0000_3104);
    chk("bst1_req",  {31'd0, imem_req}, 32'd0);
    chk("bst1_inst", instd, 32'h8888_0008);
    stalld = 1'b0;
    tick();
    chk("bst2_addr",  imem_addr, 32'h0000_3200);
    chk("bst2_valid", {31'd0, validd}, 32'd0);
    chk("bst2_req",   {31'd0, imem_req}, 32'd1);
    branchd    = 1'b0;
    equald     = 1'b0;
    imem_rdata = 32'hAAAA_000A;
    tick();
    chk("bst3_inst", instd, 32'hAAAA_000A);
    chk("bst3_addr", imem_addr, 32'h0000_3204);

    // Reset pulsed mid-request with RDY low
    imem_rdy = 1'b0;
    tick();
    chk("mr_valid0", {31'd0, validd}, 32'd0);
    clrn = 1'b0;
    #1;
    chk("mr_req",   {31'd0, imem_req}, 32'd0);
    chk("mr_valid", {31'd0, validd}, 32'd0);
    chk("mr_addr",  imem_addr, 32'h0000_3000);
    tick();
    clrn       = 1'b1;
    imem_rdy   = 1'b1;
    imem_rdata = 32'hBEEF_BEEF;
    tick();
    chk("mr2_req",   {31'd0, imem_req}, 32'd1);
    chk("mr2_addr",  imem_addr, 32'h0000_3000);
    chk("mr2_valid", {31'd0, validd}, 32'd0);
    imem_rdata = 32'hCCCC_000C;
    tick();
    chk("mr3_inst", instd, 32'hCCCC_000C);
    chk("mr3_addr", imem_addr, 32'h0000_3004);

    // PC wrap: jump to top word, then PC+4 wraps to zero
    jmpd       = 1'b1;
    pcjumpd    = 32'hFFFF_FFFF;
    imem_rdata = 32'h0;
    tick();
    chk("wrap1_addr", imem_addr, 32'hFFFF_FFFC);
    jmpd       = 1'b0;
    imem_rdata = 32'hDDDD_000D;
    tick();
    chk("wrap2_inst", instd, 32'hDDDD_000D);
    chk("wrap2_pc4",  pcplus4d, 32'h0000_0000);
    chk("wrap2_addr", imem_addr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
